dvb_s2_cfg_sequencer: RTL

Controls the DVB-S/S2 modulator configuration. Software writes to shadow registers. On a commit, the block waits for the current frame to finish, holds the datapath in soft reset, loads the shadow set into the active configuration, and then releases the datapath. The block sits between the AXI register slice and `dvb_s2_system_top`/`dvb_s2_srrc_filter`, and supplies their `hard_rst_n` and all mode inputs.

---
 rtl/dvb_s2_cfg_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dvb_s2_cfg_sequencer.sv
// DVB-S/S2 modulator configuration sequencer.
// Software writes shadow registers; a commit waits for a frame boundary, holds the
// datapath in soft reset, copies shadow to active, then releases the datapath.
// Optional macro DVB_S2_CFG_EOF_TIMEOUT_EN bounds the end-of-frame wait with
// TIMEOUT_CYCLES and exposes a sticky timeout flag.
module dvb_s2_cfg_sequencer #(
    parameter int unsigned ADDR_BITS      = 4,
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wen,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic                 ren,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata,
    input  logic                 frame_end,
    input  logic                 dp_active,
    output logic                 dp_rst_n,
    output logic [1:0]           mod_mode,
    output logic [3:0]           ldpc_mode,
    output logic                 frame_mode,
    output logic                 pilot_mode,
    output logic [1:0]           srrc_mode,
    output logic [2:0]           conv_mode,
    output logic                 dvb_s_mode,
    output logic [1:0]           ts_source_mode,
    output logic [31:0]          baud_num,
    output logic                 freq_inv,
    output logic                 cfg_done,
    output logic                 cfg_busy
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitEof = 2'd1,
        StHold    = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam int unsigned CntW = $clog2(RST_CYCLES);

    localparam logic [ADDR_BITS-1:0] AddrMod    = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] AddrLdpc   = ADDR_BITS'(1);
    localparam logic [ADDR_BITS-1:0] AddrFrame  = ADDR_BITS'(2);
    localparam logic [ADDR_BITS-1:0] AddrPilot  = ADDR_BITS'(3);
    localparam logic [ADDR_BITS-1:0] AddrSrrc   = ADDR_BITS'(4);
    localparam logic [ADDR_BITS-1:0] AddrConv   = ADDR_BITS'(5);
    localparam logic [ADDR_BITS-1:0] AddrDvbS   = ADDR_BITS'(6);
    localparam logic [ADDR_BITS-1:0] AddrTs     = ADDR_BITS'(7);
    localparam logic [ADDR_BITS-1:0] AddrBaud   = ADDR_BITS'(8);
    localparam logic [ADDR_BITS-1:0] AddrFinv   = ADDR_BITS'(9);
    localparam logic [ADDR_BITS-1:0] AddrStatus = ADDR_BITS'(14);
    localparam logic [ADDR_BITS-1:0] AddrCommit = ADDR_BITS'(15);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic              commit_pending_q, commit_pending_d;
    logic [15:0]       reconfig_cnt_q;
    logic              done_d;
    logic              commit;
    logic              cfg_differs;
    logic              load_active;
    logic              timeout_flag;
    logic              eof_timeout;
    logic [31:0]       rd_val;

    logic [1:0]  sh_mod_q;
    logic [3:0]  sh_ldpc_q;
    logic        sh_frame_q;
    logic        sh_pilot_q;
    logic [1:0]  sh_srrc_q;
    logic [2:0]  sh_conv_q;
    logic        sh_dvb_s_q;
    logic [1:0]  sh_ts_q;
    logic [31:0] sh_baud_q;
    logic        sh_finv_q;

    assign commit      = wen && (waddr == AddrCommit) && wdata[0];
    assign cfg_differs = {sh_mod_q, sh_ldpc_q, sh_frame_q, sh_pilot_q, sh_srrc_q, sh_conv_q,
                          sh_dvb_s_q, sh_ts_q, sh_baud_q, sh_finv_q} !=
                         {mod_mode, ldpc_mode, frame_mode, pilot_mode, srrc_mode, conv_mode,
                          dvb_s_mode, ts_source_mode, baud_num, freq_inv};
    // Active set is sampled on the WAIT_EOF -> HOLD edge, so late shadow writes are included.
    assign load_active = (state_q == StWaitEof) && (state_d == StHold);

`ifdef DVB_S2_CFG_EOF_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
    logic [ToW-1:0] to_cnt_q;
    logic           timeout_flag_q;

    assign eof_timeout  = (state_q == StWaitEof) && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
    assign timeout_flag = timeout_flag_q;

    // End-of-frame wait counter and sticky timeout flag (a real frame boundary wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == StWaitEof) ? to_cnt_q + 1'b1 : '0;
            if (eof_timeout && !frame_end && dp_active) begin
                timeout_flag_q <= 1'b1;
            end else if (wen && (waddr == AddrStatus)) begin
                timeout_flag_q <= 1'b0;
            end
        end
    end
`else
    assign eof_timeout  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // Shadow registers: software writes land here in any state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_mod_q   <= 2'd0;
            sh_ldpc_q  <= 4'd6;
            sh_frame_q <= 1'b0;
            sh_pilot_q <= 1'b0;
            sh_srrc_q  <= 2'd2;
            sh_conv_q  <= 3'd0;
            sh_dvb_s_q <= 1'b1;
            sh_ts_q    <= 2'd2;
            sh_baud_q  <= 32'd2500;
            sh_finv_q  <= 1'b0;
        end else if (wen) begin
            case (waddr)
                AddrMod:   sh_mod_q   <= wdata[1:0];
                AddrLdpc:  sh_ldpc_q  <= wdata[3:0];
                AddrFrame: sh_frame_q <= wdata[0];
                AddrPilot: sh_pilot_q <= wdata[0];
                AddrSrrc:  sh_srrc_q  <= wdata[1:0];
                AddrConv:  sh_conv_q  <= wdata[2:0];
                AddrDvbS:  sh_dvb_s_q <= wdata[0];
                AddrTs:    sh_ts_q    <= wdata[1:0];
                AddrBaud:  sh_baud_q  <= wdata;
                AddrFinv:  sh_finv_q  <= wdata[0];
                default: ;
            endcase
        end
    end

    // Active configuration, copied from shadow on HOLD entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mod_mode       <= 2'd0;
            ldpc_mode      <= 4'd6;
            frame_mode     <= 1'b0;
            pilot_mode     <= 1'b0;
            srrc_mode      <= 2'd2;
            conv_mode      <= 3'd0;
            dvb_s_mode     <= 1'b1;
            ts_source_mode <= 2'd2;
            baud_num       <= 32'd2500;
            freq_inv       <= 1'b0;
        end else if (load_active) begin
            mod_mode       <= sh_mod_q;
            ldpc_mode      <= sh_ldpc_q;
            frame_mode     <= sh_frame_q;
            pilot_mode     <= sh_pilot_q;
            srrc_mode      <= sh_srrc_q;
            conv_mode      <= sh_conv_q;
            dvb_s_mode     <= sh_dvb_s_q;
            ts_source_mode <= sh_ts_q;
            baud_num       <= sh_baud_q;
            freq_inv       <= sh_finv_q;
        end
    end

    // Next-state logic; commits seen in DONE are folded into the pending decision.
    always_comb begin
        state_d          = state_q;
        commit_pending_d = commit_pending_q;
        done_d           = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    if (cfg_differs) state_d = StWaitEof;
                    else             done_d  = 1'b1;
                end
            end
            StWaitEof: begin
                if (frame_end || !dp_active || eof_timeout) state_d = StHold;
            end
            StHold: begin
                if (cnt_q == CntW'(RST_CYCLES - 1)) state_d = StDone;
            end
            StDone: begin
                commit_pending_d = 1'b0;
                state_d = ((commit_pending_q || commit) && cfg_differs) ? StWaitEof : StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (commit && (state_q == StWaitEof || state_q == StHold)) commit_pending_d = 1'b1;
        if (state_d == StDone) done_d = 1'b1;
    end

    // State, hold counter, bookkeeping and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StHold;
            cnt_q            <= '0;
            commit_pending_q <= 1'b0;
            reconfig_cnt_q   <= 16'd0;
            dp_rst_n         <= 1'b0;
            cfg_done         <= 1'b0;
            cfg_busy         <= 1'b1;
        end else begin
            state_q          <= state_d;
            cnt_q            <= (state_q == StHold) ? cnt_q + 1'b1 : '0;
            commit_pending_q <= commit_pending_d;
            if (state_q == StDone) reconfig_cnt_q <= reconfig_cnt_q + 16'd1;
            dp_rst_n         <= (state_d != StHold);
            cfg_done         <= done_d;
            cfg_busy         <= (state_d != StIdle);
        end
    end

    // Read mux: active fields, status word, or a tagged marker for unmapped addresses.
    always_comb begin
        rd_val = 32'hE000_0000 | 32'(raddr);
        case (raddr)
            AddrMod:    rd_val = 32'(mod_mode);
            AddrLdpc:   rd_val = 32'(ldpc_mode);
            AddrFrame:  rd_val = 32'(frame_mode);
            AddrPilot:  rd_val = 32'(pilot_mode);
            AddrSrrc:   rd_val = 32'(srrc_mode);
            AddrConv:   rd_val = 32'(conv_mode);
            AddrDvbS:   rd_val = 32'(dvb_s_mode);
            AddrTs:     rd_val = 32'(ts_source_mode);
            AddrBaud:   rd_val = baud_num;
            AddrFinv:   rd_val = 32'(freq_inv);
            AddrStatus: rd_val = {1'b0, reconfig_cnt_q, 9'b0, commit_pending_q, dp_rst_n,
                                  timeout_flag, state_q, cfg_busy};
            default: ;
        endcase
    end

    // Registered read data, one cycle after ren.
    always_ff @(posedge clk) begin
        if (!rst_n)   rdata <= 32'd0;
        else if (ren) rdata <= rd_val;
    end

endmodule
